// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 between the L1 line miss port and main memory.
// Hits complete in one cycle; misses write back a dirty victim, then fetch (reads only).
module l2_cache #(
    parameter int NUM_OF_LINES = 64,
    parameter int IDX_W        = $clog2(NUM_OF_LINES),
    parameter int TAG_W        = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [27:0]  l1_addr,
    input  logic [127:0] l1_wdata,
    output logic [127:0] l1_rdata,
    output logic         l1_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    typedef enum logic [1:0] {IDLE, WB, FETCH, RESP} state_t;
    state_t state, next_state;

    logic [127:0]            line_mem [NUM_OF_LINES];
    logic [TAG_W-1:0]        tag_mem  [NUM_OF_LINES];
    logic [NUM_OF_LINES-1:0] valid, dirty;
    logic [127:0]            rdata_q;
    logic                    mem_read_q, mem_write_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic rd, wr, req, hit, victim_dirty;
    logic wb_done, fetch_done, install_wr, hit_wr, line_we;

    assign idx          = l1_addr[IDX_W-1:0];
    assign tag          = l1_addr[27:IDX_W];
    assign rd           = l1_read & ~l1_write;
    assign wr           = l1_write & ~l1_read;
    assign req          = (state == IDLE) && (rd || wr);
    assign hit          = valid[idx] && (tag_mem[idx] == tag);
    assign victim_dirty = valid[idx] && dirty[idx];

    // mem_ready only counts while our own request is actually on the bus
    assign wb_done    = (state == WB) && mem_write_q && mem_ready;
    assign fetch_done = (state == FETCH) && mem_read_q && mem_ready;
    assign install_wr = (req && wr && !hit && !victim_dirty) || (wb_done && wr);
    assign hit_wr     = req && wr && hit;
    assign line_we    = install_wr || hit_wr || fetch_done;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) state <= IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit)               next_state = RESP;
                    else if (victim_dirty) next_state = WB;
                    else if (rd)           next_state = FETCH;
                    else                   next_state = RESP;
                end
            end
            WB:      if (wb_done) next_state = wr ? RESP : FETCH;
            FETCH:   if (fetch_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        l1_ready  = (state == RESP);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_write_q) begin
            mem_addr  = {tag_mem[idx], idx};
            mem_wdata = line_mem[idx];
        end else if (mem_read_q) begin
            mem_addr = l1_addr;
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign l1_rdata   = rdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // A FETCH entered from WB starts with mem_read low, giving the bus one idle cycle
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            mem_write_q <= (req && next_state == WB) || ((state == WB) && mem_write_q && !mem_ready);
            mem_read_q  <= (req && next_state == FETCH) || ((state == FETCH) && !fetch_done);
        end
    end

    always_ff @(posedge clk) begin
        if (line_we)                   line_mem[idx] <= fetch_done ? mem_rdata : l1_wdata;
        if (install_wr || fetch_done)  tag_mem[idx]  <= tag;
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            valid   <= '0;
            dirty   <= '0;
            rdata_q <= '0;
        end else begin
            if (wb_done)                  dirty[idx] <= 1'b0;
            if (install_wr || hit_wr)     dirty[idx] <= 1'b1;
            if (fetch_done)               dirty[idx] <= 1'b0;
            if (install_wr || fetch_done) valid[idx] <= 1'b1;
            if (req && rd && hit)         rdata_q    <= line_mem[idx];
            if (fetch_done)               rdata_q    <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (req) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Scoreboarded bench for l2_cache: expected memory transactions and L1 responses are queued
// as stimulus is issued, and popped as the DUT presents them.
module tb_l2_cache;
    typedef struct packed {
        logic         we;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    typedef struct packed {
        logic         is_rd;
        logic [127:0] rdata;
    } rsp_t;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D1  = {4{32'h1111_0001}};
    localparam logic [127:0] D2  = {4{32'h2222_0002}};
    localparam logic [127:0] D3  = {4{32'h3333_0003}};
    localparam logic [127:0] D4  = {4{32'h4444_0004}};
    localparam logic [127:0] D5  = {4{32'h5555_0005}};

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         l1_read, l1_write;
    logic [27:0]  l1_addr;
    logic [127:0] l1_wdata, l1_rdata;
    logic         l1_ready, mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic [31:0]  hit_count, miss_count;

    mem_txn_t exp_mem_q[$];
    rsp_t     exp_rsp_q[$];
    int       vectors = 0;
    int       miscompares = 0;

    l2_cache dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .l1_read(l1_read), .l1_write(l1_write), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
        .l1_rdata(l1_rdata), .l1_ready(l1_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic push_mem(input logic we, input logic [27:0] addr, input logic [127:0] data);
        mem_txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        exp_mem_q.push_back(t);
    endtask

    task automatic push_rsp(input logic is_rd, input logic [127:0] rdata);
        rsp_t r;
        r.is_rd = is_rd; r.rdata = rdata;
        exp_rsp_q.push_back(r);
    endtask

    // Drive one L1 request, act as main memory (2-cycle latency), return L1 latency and
    // the distance from the last mem_ready pulse to l1_ready.
    task automatic run_req(input logic rd, input logic wr, input logic [27:0] addr,
                           input logic [127:0] wdata, output int lat, output int rdy_gap);
        mem_txn_t t;
        rsp_t     r;
        bit       pend;
        int       cnt, mr_cyc;
        pend = 1'b0; cnt = 0; mr_cyc = -100; lat = -1; rdy_gap = -1; t = '0;
        l1_read = rd; l1_write = wr; l1_addr = addr; l1_wdata = wdata;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                mem_ready = 1'b0; mem_rdata = '0; pend = 1'b0;
                vectors++;
                if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_wdata !== '0) begin
                    miscompares++;
                    $display("FAIL mem_release: rd=%b wr=%b wdata=%h, required rd=0 wr=0 wdata=0",
                             mem_read, mem_write, mem_wdata);
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = t.we ? '0 : t.data;
                    mr_cyc    = cyc;
                end else cnt--;
            end else if (mem_read || mem_write) begin
                vectors++;
                if (exp_mem_q.size() == 0) begin
                    t.we = mem_write; t.addr = mem_addr; t.data = '0;
                    miscompares++;
                    $display("FAIL mem_unexpected: got rd=%b wr=%b addr=%h, required no memory access",
                             mem_read, mem_write, mem_addr);
                end else begin
                    t = exp_mem_q.pop_front();
                    if (mem_write !== t.we || mem_read !== !t.we || mem_addr !== t.addr ||
                        mem_wdata !== (t.we ? t.data : 128'd0)) begin
                        miscompares++;
                        $display("FAIL mem_txn: got wr=%b rd=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                                 mem_write, mem_read, mem_addr, mem_wdata, t.we, t.addr,
                                 t.we ? t.data : 128'd0);
                    end
                end
                pend = 1'b1; cnt = 1;
            end
            if (l1_ready) begin
                lat = cyc; rdy_gap = cyc - mr_cyc;
                l1_read = 1'b0; l1_write = 1'b0;
                if (exp_rsp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rsp_unexpected: got l1_ready=1, required no response");
                end else begin
                    r = exp_rsp_q.pop_front();
                    if (r.is_rd) begin
                        vectors++;
                        if (l1_rdata !== r.rdata) begin
                            miscompares++;
                            $display("FAIL l1_rdata: got %h, required %h", l1_rdata, r.rdata);
                        end
                    end
                end
                break;
            end
        end
        l1_read = 1'b0; l1_write = 1'b0;
        if (lat < 0) begin
            vectors++; miscompares++;
            $display("FAIL req_timeout: got no l1_ready in 200 cycles, required a response");
        end
        @(posedge clk); #1;
        vectors++;
        if (l1_ready !== 1'b0 || exp_mem_q.size() != 0) begin
            miscompares++;
            $display("FAIL ready_pulse: got l1_ready=%b pending_mem=%0d, required 0 and 0",
                     l1_ready, exp_mem_q.size());
        end
    endtask

    task automatic check_counts(input string name, input logic [31:0] h, input logic [31:0] m);
        vectors++;
        if (hit_count !== h || miss_count !== m) begin
            miscompares++;
            $display("FAIL %s: got hit=%h miss=%h, required hit=%h miss=%h",
                     name, hit_count, miss_count, h, m);
        end
    endtask

    task automatic test_reset();
        proc_reset_n = 1'b0;
        l1_read = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #12;
        vectors++;
        if ({l1_ready, mem_read, mem_write} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0 ||
            l1_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b addr=%h rdata=%h, required all 0",
                     l1_ready, mem_read, mem_write, mem_addr, l1_rdata);
        end
        check_counts("reset_counters", 32'd0, 32'd0);
        @(negedge clk); proc_reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss_and_hit();
        int lat, gap;
        push_mem(1'b0, 28'h0000040, DA5);
        push_rsp(1'b1, DA5);
        run_req(1'b1, 1'b0, 28'h0000040, '0, lat, gap);
        vectors++;
        if (gap !== 1) begin
            miscompares++;
            $display("FAIL fetch_ready_gap: got %0d, required 1", gap);
        end
        check_counts("cold_miss_count", 32'd0, 32'd1);
        push_rsp(1'b1, DA5);
        run_req(1'b1, 1'b0, 28'h0000040, '0, lat, gap);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL read_hit_latency: got %0d, required 1", lat);
        end
        check_counts("read_hit_count", 32'd1, 32'd1);
    endtask

    task automatic test_clean_write_miss();
        int lat, gap;
        push_rsp(1'b0, '0);
        run_req(1'b0, 1'b1, 28'h0000081, D1, lat, gap);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL clean_wr_latency: got %0d, required 1", lat);
        end
        push_rsp(1'b1, D1);
        run_req(1'b1, 1'b0, 28'h0000081, '0, lat, gap);
        check_counts("clean_wr_count", 32'd2, 32'd2);
    endtask

    task automatic test_dirty_victim();
        int lat, gap;
        push_mem(1'b1, 28'h0000081, D1);
        push_mem(1'b0, 28'h0000041, D2);
        push_rsp(1'b1, D2);
        run_req(1'b1, 1'b0, 28'h0000041, '0, lat, gap);
        check_counts("dirty_rd_count", 32'd2, 32'd3);
        // idx 1 now holds a clean fetched line; write a new tag, then evict it by writing
        push_rsp(1'b0, '0);
        run_req(1'b0, 1'b1, 28'h00000C1, D3, lat, gap);
        push_mem(1'b1, 28'h00000C1, D3);
        push_rsp(1'b0, '0);
        run_req(1'b0, 1'b1, 28'h0000041, D4, lat, gap);
        vectors++;
        if (gap !== 1) begin
            miscompares++;
            $display("FAIL wb_write_ready_gap: got %0d, required 1", gap);
        end
        push_rsp(1'b1, D4);
        run_req(1'b1, 1'b0, 28'h0000041, '0, lat, gap);
        check_counts("dirty_wr_count", 32'd3, 32'd5);
    endtask

    task automatic test_both_asserted();
        bit seen;
        seen = 1'b0;
        l1_read = 1'b1; l1_write = 1'b1; l1_addr = 28'h0000041; l1_wdata = D5;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (l1_ready || mem_read || mem_write) seen = 1'b1;
        end
        l1_read = 1'b0; l1_write = 1'b0;
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL both_noop: got activity=1, required 0");
        end
        check_counts("both_counts", 32'd3, 32'd5);
    endtask

    task automatic test_saturation();
        int lat, gap;
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        push_rsp(1'b1, D4);
        run_req(1'b1, 1'b0, 28'h0000041, '0, lat, gap);
        check_counts("sat_reach", 32'hFFFF_FFFF, 32'd5);
        push_rsp(1'b1, DA5);
        run_req(1'b1, 1'b0, 28'h0000040, '0, lat, gap);
        check_counts("sat_hold", 32'hFFFF_FFFF, 32'd5);
    endtask

    task automatic test_reset_mid_fetch();
        bit seen;
        int lat, gap;
        seen = 1'b0;
        l1_read = 1'b1; l1_write = 1'b0; l1_addr = 28'h0000200;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_start: got mem_read=0, required 1");
        end
        #2 proc_reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || l1_ready !== 1'b0 || mem_addr !== '0) begin
            miscompares++;
            $display("FAIL async_abort: got rd=%b wr=%b rdy=%b addr=%h, required all 0",
                     mem_read, mem_write, l1_ready, mem_addr);
        end
        check_counts("abort_counters", 32'd0, 32'd0);
        l1_read = 1'b0;
        @(negedge clk); proc_reset_n = 1'b1;
        @(posedge clk); #1;
        push_mem(1'b0, 28'h0000200, D5);
        push_rsp(1'b1, D5);
        run_req(1'b1, 1'b0, 28'h0000200, '0, lat, gap);
        check_counts("post_reset_miss", 32'd0, 32'd1);
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_clean_write_miss();
        test_dirty_victim();
        test_both_asserted();
        test_saturation();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end
endmodule
